// File: rtl/bcd_cmd_if.sv
// Command handshake bundle for bcd_count_ctrl: one LOAD/RUN/STOP command per
// cmd_valid & cmd_ready cycle.
interface bcd_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/bcd_count_ctrl.sv
// Sequencer for four BCD counter slices with prescaled counting and carry/borrow cascade.
// Optional feature macro: BCD_CTRL_STOP_AT_LIMIT_EN (stop at 9999/0000 instead of wrapping).
module bcd_count_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  bcd_cmd_if.slave    cmd,
  output logic [15:0] dig_load,
  output logic [3:0]  dig_enter,
  output logic [3:0]  dig_mode,
  output logic [15:0] count_q,
  output logic        running,
  output logic        wrap,
  output logic        load_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [1:0]  OP_LOAD     = 2'b00;
  localparam logic [1:0]  OP_RUN_UP   = 2'b01;
  localparam logic [1:0]  OP_RUN_DOWN = 2'b10;
  localparam logic [1:0]  OP_STOP     = 2'b11;
  localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic        dir_q, dir_d;          // 1 = up, 0 = down
  logic [15:0] presc_q, presc_d;
  logic [15:0] load_q, load_d;
  logic [15:0] count_d;
  logic        wrap_q, wrap_d;
  logic        load_err_q, load_err_d;

  logic        accept;
  logic        tick;
  logic        step_en;
  logic        step_ok;
  logic        all_lim;
  logic [3:0]  at_lim;
  logic [3:0]  step;
  logic [15:0] load_clean;
  logic        load_bad;

  // Valid/ready: a command is taken on any cycle where cmd_valid and cmd_ready
  // are both high; cmd_ready drops only during the one LOAD cycle and reset.
  assign cmd.cmd_ready = (state_q != S_LOAD) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign tick          = (state_q == S_RUN) && (presc_q == TICK_LAST);
  assign running       = (state_q == S_RUN);
  assign wrap          = wrap_q;
  assign load_err      = load_err_q;
  assign state_dbg     = state_q;

  // Any accepted command in RUN supersedes a due tick (STOP must not step).
  always_comb begin
    step_en = tick && !accept;
    for (int i = 0; i < 4; i++) begin
      at_lim[i] = dir_q ? (count_q[i*4 +: 4] == 4'd9) : (count_q[i*4 +: 4] == 4'd0);
    end
    all_lim = &at_lim;
`ifdef BCD_CTRL_STOP_AT_LIMIT_EN
    step_ok = step_en && !all_lim;
`else
    step_ok = step_en;
`endif
    step[0] = step_ok;
    for (int i = 1; i < 4; i++) begin
      step[i] = step[i-1] && at_lim[i-1];
    end
  end

  always_comb begin
    load_bad   = 1'b0;
    load_clean = cmd.cmd_data;
    for (int i = 0; i < 4; i++) begin
      if (cmd.cmd_data[i*4 +: 4] > 4'd9) begin
        load_clean[i*4 +: 4] = 4'd0;
        load_bad             = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    load_d     = load_q;
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_LOAD: begin
              state_d    = S_LOAD;
              load_d     = load_clean;
              load_err_d = load_bad;
            end
            OP_RUN_UP: begin
              state_d = S_RUN;
              dir_d   = 1'b1;
            end
            OP_RUN_DOWN: begin
              state_d = S_RUN;
              dir_d   = 1'b0;
            end
            OP_STOP: state_d = S_IDLE;
            default: state_d = state_q;
          endcase
        end
      end
      S_LOAD: begin
        count_d = load_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < 4; i++) begin
      if (step[i]) begin
        if (dir_q) count_d[i*4 +: 4] = (count_q[i*4 +: 4] == 4'd9) ? 4'd0 : count_q[i*4 +: 4] + 4'd1;
        else       count_d[i*4 +: 4] = (count_q[i*4 +: 4] == 4'd0) ? 4'd9 : count_q[i*4 +: 4] - 4'd1;
      end
    end

    if (step_en && all_lim) begin
      wrap_d = 1'b1;
`ifdef BCD_CTRL_STOP_AT_LIMIT_EN
      state_d = S_IDLE;
`endif
    end

    presc_d = (state_d == S_RUN && !accept && !tick) ? presc_q + 16'd1 : 16'd0;
  end

  always_comb begin
    dig_mode = {4{dir_q}};
    if (rst) begin
      dig_enter = 4'hF;
      dig_load  = 16'h0000;
    end else if (state_q == S_LOAD) begin
      dig_enter = 4'hF;
      dig_load  = load_q;
    end else begin
      dig_enter = ~step;
      dig_load  = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b1;
      presc_q    <= 16'd0;
      load_q     <= 16'd0;
      count_q    <= 16'd0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      presc_q    <= presc_d;
      load_q     <= load_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with a behavioural model of the four digit slices.
module tb_bcd_count_ctrl;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_RUN_UP   = 2'b01;
  localparam logic [1:0] OP_RUN_DOWN = 2'b10;
  localparam logic [1:0] OP_STOP     = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dig_load;
  logic [3:0]  dig_enter;
  logic [3:0]  dig_mode;
  logic [15:0] count_q;
  logic        running;
  logic        wrap;
  logic        load_err;
  logic [1:0]  state_dbg;

  bcd_cmd_if cmd_if ();

  bcd_count_ctrl #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .dig_load  (dig_load),
    .dig_enter (dig_enter),
    .dig_mode  (dig_mode),
    .count_q   (count_q),
    .running   (running),
    .wrap      (wrap),
    .load_err  (load_err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // independent slice model: take load when enter, else step by mode
  logic [3:0] slice [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dig_enter[i])   slice[i] <= dig_load[i*4 +: 4];
      else if (dig_mode[i]) slice[i] <= (slice[i] == 4'd9) ? 4'd0 : slice[i] + 4'd1;
      else                slice[i] <= (slice[i] == 4'd0) ? 4'd9 : slice[i] - 4'd1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_slices(input string name, input logic [15:0] exp);
    check(name, {slice[3], slice[2], slice[1], slice[0]}, exp);
  endtask

  // caller is at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [1:0] op, input logic [15:0] data);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] data);
    send(OP_LOAD, data);
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_count;
    logic        exp_err;
  } load_vec_t;

  load_vec_t vecs [6];

  initial begin
    vecs[0] = '{16'h0123, 16'h0123, 1'b0};
    vecs[1] = '{16'hA5F3, 16'h0503, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1};
    vecs[3] = '{16'h9999, 16'h9999, 1'b0};
    vecs[4] = '{16'h9A09, 16'h9009, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0};

    rst              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_STOP;
    cmd_if.cmd_data  = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_enter", {12'h0, dig_enter}, 16'h000F);
    check("rst_load", dig_load, 16'h0000);
    check("rst_ready", {15'h0, cmd_if.cmd_ready}, 16'h0);
    rst = 1'b0;
    #1;
    check("reset_count", count_q, 16'h0000);
    check("reset_flags", {13'h0, running, wrap, load_err}, 16'h0);
    check("reset_ready", {15'h0, cmd_if.cmd_ready}, 16'h1);
    check("reset_mode_up", {12'h0, dig_mode}, 16'h000F);
    check_slices("reset_slices", 16'h0000);
    @(negedge clk);

    // LOAD table
    for (int i = 0; i < 6; i++) begin
      send(OP_LOAD, vecs[i].data);
      check($sformatf("load%0d_ready_low", i), {15'h0, cmd_if.cmd_ready}, 16'h0);
      check($sformatf("load%0d_err", i), {15'h0, load_err}, {15'h0, vecs[i].exp_err});
      @(negedge clk);
      check($sformatf("load%0d_count", i), count_q, vecs[i].exp_count);
      check($sformatf("load%0d_err_clear", i), {15'h0, load_err}, 16'h0);
      check($sformatf("load%0d_ready_back", i), {15'h0, cmd_if.cmd_ready}, 16'h1);
      check_slices($sformatf("load%0d_slices", i), vecs[i].exp_count);
    end

    // carry ripple 0098 -> 0099 -> 0100
    do_load(16'h0098);
    send(OP_RUN_UP, 16'h0);
    check("run_running", {15'h0, running}, 16'h1);
    check("run_no_step_yet", count_q, 16'h0098);
    repeat (4) @(negedge clk);
    check("run_first_step", count_q, 16'h0099);
    repeat (3) @(negedge clk);
    check("carry_enter", {12'h0, dig_enter}, 16'h0008);
    @(negedge clk);
    check("carry_count", count_q, 16'h0100);
    check_slices("carry_slices", 16'h0100);
    send(OP_STOP, 16'h0);
    check("stop_idle", {15'h0, running}, 16'h0);

    // up wrap 9999
    do_load(16'h9999);
    send(OP_RUN_UP, 16'h0);
    repeat (4) @(negedge clk);
`ifdef BCD_CTRL_STOP_AT_LIMIT_EN
    check("upwrap_count", count_q, 16'h9999);
    check("upwrap_pulse", {15'h0, wrap}, 16'h1);
    check("upwrap_running", {15'h0, running}, 16'h0);
`else
    check("upwrap_count", count_q, 16'h0000);
    check("upwrap_pulse", {15'h0, wrap}, 16'h1);
    check("upwrap_running", {15'h0, running}, 16'h1);
`endif
    @(negedge clk);
    check("upwrap_pulse_end", {15'h0, wrap}, 16'h0);
    send(OP_STOP, 16'h0);

    // down wrap 0000, then STOP on a tick cycle
    do_load(16'h0000);
    send(OP_RUN_DOWN, 16'h0);
    check("down_mode", {12'h0, dig_mode}, 16'h0000);
    repeat (4) @(negedge clk);
`ifdef BCD_CTRL_STOP_AT_LIMIT_EN
    check("dnwrap_count", count_q, 16'h0000);
    check("dnwrap_pulse", {15'h0, wrap}, 16'h1);
    check("dnwrap_running", {15'h0, running}, 16'h0);
`else
    check("dnwrap_count", count_q, 16'h9999);
    check("dnwrap_pulse", {15'h0, wrap}, 16'h1);
    repeat (3) @(negedge clk);
    check("tick_enter", {12'h0, dig_enter}, 16'h000E);
    send(OP_STOP, 16'h0);
    check("stop_on_tick_count", count_q, 16'h9999);
    check("stop_on_tick_running", {15'h0, running}, 16'h0);
    repeat (4) @(negedge clk);
    check("stop_held", count_q, 16'h9999);
    check_slices("stop_slices", 16'h9999);
`endif

    // reset mid-run at 4321
    do_load(16'h4321);
    send(OP_RUN_UP, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_enter", {12'h0, dig_enter}, 16'h000F);
    check("midrst_load", dig_load, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_count", count_q, 16'h0000);
    check("midrst_running", {15'h0, running}, 16'h0);
    check_slices("midrst_slices", 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
